// File: rtl/arith_pkg.sv
// Shared definitions for the arithmetic lab datapath blocks.
package arith_pkg;

    localparam int DIV_WIDTH = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/subtractor.sv
// Combinational a - b with the borrow out of the top bit.
module subtractor #(
    parameter int W = 6
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] diff,
    output logic         borrow
);

    assign {borrow, diff} = {1'b0, a} - {1'b0, b};

endmodule

// File: rtl/seq_divider.sv
// Restoring shift-and-subtract divider, one quotient bit per clock.
// state | meaning
// IDLE  | waiting for start; operands captured on accept
// RUN   | one trial subtraction per edge, WIDTH edges total
// DONE  | one-cycle done pulse, results valid
module seq_divider
    import arith_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH,
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero
);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] q_reg;
    logic [WIDTH-1:0] d_reg;

    logic [WIDTH:0]   a_sh;
    logic [WIDTH:0]   t_diff;
    logic             t_borrow;
    logic             take;
    logic [WIDTH-1:0] a_next;
    logic [WIDTH-1:0] q_next;
    logic             cnt_last;

    // Restored remainder stays below D, so its top bit is always zero and
    // only WIDTH bits are held; the shifted value needs the full WIDTH+1.
    assign a_sh = {a_reg, q_reg[WIDTH-1]};

    subtractor #(.W(WIDTH + 1)) u_sub (
        .a      (a_sh),
        .b      ({1'b0, d_reg}),
        .diff   (t_diff),
        .borrow (t_borrow)
    );

    // a_sh < 2*D, so the sign bit and the borrow agree on a failed trial.
    assign take     = ~(t_diff[WIDTH] | t_borrow);
    assign a_next   = take ? t_diff[WIDTH-1:0] : a_sh[WIDTH-1:0];
    assign q_next   = {q_reg[WIDTH-2:0], take};
    assign cnt_last = (cnt == CNT_W'(WIDTH - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = (divisor == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (cnt_last) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt         <= '0;
            a_reg       <= '0;
            q_reg       <= '0;
            d_reg       <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        if (divisor == '0) begin
                            quotient    <= '1;
                            remainder   <= dividend;
                            div_by_zero <= 1'b1;
                        end else begin
                            q_reg       <= dividend;
                            d_reg       <= divisor;
                            a_reg       <= '0;
                            cnt         <= '0;
                            div_by_zero <= 1'b0;
                        end
                    end
                end
                RUN: begin
                    a_reg <= a_next;
                    q_reg <= q_next;
                    cnt   <= cnt + 1'b1;
                    if (cnt_last) begin
                        quotient  <= q_next;
                        remainder <= a_next;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
// Directed and sweep checks for seq_divider.
module tb_seq_divider;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [4:0] dividend;
    logic [4:0] divisor;
    logic [4:0] quotient;
    logic [4:0] remainder;
    logic       busy;
    logic       done;
    logic       div_by_zero;

    int n_checks = 0;
    int n_fail   = 0;

    seq_divider dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .quotient    (quotient),
        .remainder   (remainder),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Called at a negedge; accept happens on the following posedge.
    task automatic start_op(input logic [4:0] dd, input logic [4:0] dv);
        dividend = dd;
        divisor  = dv;
        start    = 1'b1;
        @(negedge clk);
        start    = 1'b0;
    endtask

    // Waits for done, then steps one more negedge into IDLE.
    task automatic wait_done(output int cyc, output int nbusy, output int done_len);
        cyc   = 0;
        nbusy = 0;
        while (!done && cyc < 50) begin
            if (busy) nbusy++;
            @(negedge clk);
            cyc++;
        end
        if (cyc >= 50) chk("done_timeout", 0, 1);
        done_len = 0;
        while (done && done_len < 5) begin
            done_len++;
            @(negedge clk);
        end
    endtask

    int cyc, nbusy, dlen, extra;

    initial begin
        rst_n    = 1'b0;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        #12;
        chk("rst_quotient", quotient, 0);
        chk("rst_remainder", remainder, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_dbz", div_by_zero, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        start_op(5'd23, 5'd4);
        wait_done(cyc, nbusy, dlen);
        chk("23/4_latency", cyc, 5);
        chk("23/4_busy_cycles", nbusy, 5);
        chk("23/4_done_len", dlen, 1);
        chk("23/4_q", quotient, 5);
        chk("23/4_r", remainder, 3);
        chk("23/4_dbz", div_by_zero, 0);

        start_op(5'd31, 5'd1);
        wait_done(cyc, nbusy, dlen);
        repeat (3) @(negedge clk);
        chk("31/1_q_hold", quotient, 31);
        chk("31/1_r_hold", remainder, 0);
        start_op(5'd7, 5'd9);
        wait_done(cyc, nbusy, dlen);
        chk("7/9_q", quotient, 0);
        chk("7/9_r", remainder, 7);

        start_op(5'd12, 5'd0);
        wait_done(cyc, nbusy, dlen);
        chk("12/0_latency", cyc, 0);
        chk("12/0_busy", nbusy, 0);
        chk("12/0_done_len", dlen, 1);
        chk("12/0_q", quotient, 31);
        chk("12/0_r", remainder, 12);
        chk("12/0_dbz", div_by_zero, 1);
        repeat (2) @(negedge clk);
        chk("12/0_dbz_hold", div_by_zero, 1);
        start_op(5'd10, 5'd3);
        wait_done(cyc, nbusy, dlen);
        chk("10/3_q", quotient, 3);
        chk("10/3_r", remainder, 1);
        chk("10/3_dbz", div_by_zero, 0);

        // Second start and operand changes mid-run must be ignored.
        start_op(5'd30, 5'd7);
        @(negedge clk);
        start_op(5'd9, 5'd2);
        dividend = 5'd17;
        divisor  = 5'd0;
        wait_done(cyc, nbusy, dlen);
        chk("30/7_q", quotient, 4);
        chk("30/7_r", remainder, 2);
        chk("30/7_dbz", div_by_zero, 0);
        extra = 0;
        repeat (10) begin
            if (done || busy) extra++;
            @(negedge clk);
        end
        chk("30/7_no_extra_op", extra, 0);

        // Asynchronous reset in the middle of a run.
        start_op(5'd29, 5'd5);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_q", quotient, 0);
        chk("abort_r", remainder, 0);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_dbz", div_by_zero, 0);
        extra = 0;
        repeat (8) begin
            @(negedge clk);
            if (done || busy) extra++;
        end
        rst_n = 1'b1;
        repeat (8) begin
            @(negedge clk);
            if (done || busy) extra++;
        end
        chk("abort_no_done", extra, 0);
        start_op(5'd29, 5'd5);
        wait_done(cyc, nbusy, dlen);
        chk("29/5_q", quotient, 5);
        chk("29/5_r", remainder, 4);

        // Back-to-back sweep of every nonzero-divisor pair.
        for (int dd = 0; dd < 32; dd++) begin
            for (int dv = 1; dv < 32; dv++) begin
                start_op(5'(dd), 5'(dv));
                wait_done(cyc, nbusy, dlen);
                if (quotient != 5'(dd / dv) || remainder != 5'(dd % dv)) begin
                    chk($sformatf("sweep_%0d/%0d_q", dd, dv), quotient, dd / dv);
                    chk($sformatf("sweep_%0d/%0d_r", dd, dv), remainder, dd % dv);
                end else begin
                    n_checks += 2;
                end
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
